multicycle_control: RTL and testbench



---
 rtl/mips_op_codes_defines.sv | 60 ++++++
 rtl/mem_wait_counter.sv | 32 +++
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_op_codes_defines.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states
// and the datapath select fields.
package mips_op_codes_defines;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL_LINK  = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [2:0] SRCB_B        = 3'b000;
  localparam logic [2:0] SRCB_FOUR     = 3'b001;
  localparam logic [2:0] SRCB_SEXT     = 3'b010;
  localparam logic [2:0] SRCB_SEXT_SH2 = 3'b011;
  localparam logic [2:0] SRCB_ZEXT     = 3'b100;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // States that hold a memory access open until the wait counter drains.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory wait counter: reloads to INIT, counts down while a memory access is
// in progress, and flags done when the count has reached zero.
module mem_wait_counter #(
  parameter logic [3:0] INIT = 4'd0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  logic [3:0] cnt_q, cnt_d;

  // Next count: reload has priority, otherwise saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = INIT;
    else if (dec && (cnt_q != 4'd0))
      cnt_d = cnt_q - 4'd1;
  end

  // Count register; reset leaves it primed for the first fetch.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= INIT;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM. Outputs are decoded combinationally from the
// current state, the memory wait counter and the opcode.
module multicycle_control
  import mips_op_codes_defines::*;
#(
  parameter int MEM_LATENCY = 0,
  parameter int ENABLE_JAL  = 1,
  parameter int OP_W        = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op_code,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            BranchNE,
  output logic            ALUSrcA,
  output logic            IorD,
  output logic [1:0]      RegDst,
  output logic [1:0]      MemtoReg,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic [2:0]      ALUSrcB,
  output logic            illegal_op,
  output logic [3:0]      state
);

  state_t state_q, state_d;
  logic   sw_q, sw_d;        // LW/SW choice captured in DECODE for MEM_ADDR
  logic   wait_done, wait_dec, op_illegal;

  // The counter only runs while a memory state is still waiting; at every
  // other time it sits at MEM_LATENCY, ready for the next memory state.
  assign wait_dec = is_mem_state(state_q) && !wait_done;

  mem_wait_counter #(.INIT(4'(MEM_LATENCY))) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (!wait_dec),
    .dec  (wait_dec),
    .done (wait_done)
  );

  // Next-state selection; the opcode is only looked at in DECODE.
  always_comb begin
    state_d    = state_q;
    sw_d       = sw_q;
    op_illegal = 1'b0;
    unique case (state_q)
      S_FETCH:     if (wait_done) state_d = S_DECODE;
      S_DECODE: begin
        state_d = S_FETCH;
        case (op_code)
          OP_W'(OP_LW):    begin state_d = S_MEM_ADDR; sw_d = 1'b0; end
          OP_W'(OP_SW):    begin state_d = S_MEM_ADDR; sw_d = 1'b1; end
          OP_W'(OP_RTYPE): state_d = S_R_EXEC;
          OP_W'(OP_ADDI),
          OP_W'(OP_ANDI),
          OP_W'(OP_ORI):   state_d = S_I_EXEC;
          OP_W'(OP_BEQ),
          OP_W'(OP_BNE):   state_d = S_BRANCH;
          OP_W'(OP_J):     state_d = S_JUMP;
          OP_W'(OP_JAL): begin
            if (ENABLE_JAL != 0) state_d = S_JAL_LINK;
            else                 op_illegal = 1'b1;
          end
          default:         op_illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR:  state_d = sw_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (wait_done) state_d = S_MEM_WB;
      S_MEM_WRITE: if (wait_done) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_ALU_WB;
      S_I_EXEC:    state_d = S_I_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
    end
  end

  // Datapath controls per state; anything not set here stays 0.
  always_comb begin
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    ALUSrcA     = 1'b0;
    IorD        = 1'b0;
    RegDst      = RD_RT;
    MemtoReg    = M2R_ALUOUT;
    ALUOp       = ALU_ADD;
    PCSource    = PCS_ALU;
    ALUSrcB     = SRCB_B;
    illegal_op  = op_illegal;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = wait_done;   // latch IR and PC+4 only once memory is ready
        PCWrite = wait_done;
      end
      S_DECODE:    ALUSrcB = SRCB_SEXT_SH2;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SEXT;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = RD_RD;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        if (op_code == OP_W'(OP_ADDI)) begin
          ALUSrcB = SRCB_SEXT;
        end else begin
          ALUOp   = ALU_LOGIC;
          ALUSrcB = SRCB_ZEXT;
        end
      end
      S_I_WB:      RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCSource    = PCS_ALUOUT;
        PCWriteCond = 1'b1;
        BranchNE    = (op_code == OP_W'(OP_BNE));
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      S_JAL_LINK: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
        RegWrite = 1'b1;
        RegDst   = RD_R31;
        MemtoReg = M2R_PC;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: four instances (L=0, L=2, L=3 with JAL, and
// L=0 without JAL) checked against directed vectors and a trace model.
module tb_multicycle_control;
  import mips_op_codes_defines::*;

  typedef struct packed {
    logic [3:0] st;
    logic mr, mw, ir, rw, pw, pwc, bne, asa, iord;
    logic [1:0] rd, m2r, aop, pcs;
    logic [2:0] asb;
    logic ill;
  } ctl_t;
  typedef ctl_t ctl_q_t[$];

  typedef struct {
    int         k;
    logic [5:0] o;
    int         cyc;
    ctl_t       exp;
    string      nm;
  } vec_t;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op [ND];
  ctl_t act [ND];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(int k);
    return (k == 1) ? 2 : ((k == 2) ? 3 : 0);
  endfunction

  function automatic int jal_of(int k);
    return (k == 3) ? 0 : 1;
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic mr, mw, ir, rw, pw, pwc, bne, asa, iord, ill;
    logic [1:0] rd, m2r, aop, pcs;
    logic [2:0] asb;
    logic [3:0] st;
    multicycle_control #(
      .MEM_LATENCY ((g == 1) ? 2 : ((g == 2) ? 3 : 0)),
      .ENABLE_JAL  ((g == 3) ? 0 : 1),
      .OP_W        (6)
    ) u_dut (
      .clk(clk), .rst(rst), .op_code(op[g]),
      .MemRead(mr), .MemWrite(mw), .IRWrite(ir), .RegWrite(rw), .PCWrite(pw),
      .PCWriteCond(pwc), .BranchNE(bne), .ALUSrcA(asa), .IorD(iord),
      .RegDst(rd), .MemtoReg(m2r), .ALUOp(aop), .PCSource(pcs), .ALUSrcB(asb),
      .illegal_op(ill), .state(st)
    );
    assign act[g] = {st, mr, mw, ir, rw, pw, pwc, bne, asa, iord, rd, m2r, aop, pcs, asb, ill};
  end

  // Build an expected control word: state, the nine 1-bit controls,
  // RegDst, MemtoReg, ALUOp, PCSource, ALUSrcB, illegal_op.
  function automatic ctl_t c(int st, int mr, int mw, int ir, int rw, int pw, int pwc,
                             int bne, int asa, int iord, int rd, int m2r, int aop,
                             int pcs, int asb, int ill);
    return {4'(st), 1'(mr), 1'(mw), 1'(ir), 1'(rw), 1'(pw), 1'(pwc), 1'(bne),
            1'(asa), 1'(iord), 2'(rd), 2'(m2r), 2'(aop), 2'(pcs), 3'(asb), 1'(ill)};
  endfunction

  // Expected per-cycle trace of one whole instruction, assembled from the
  // phase list each instruction class walks through.
  function automatic ctl_q_t model(logic [5:0] o, int L, int jal);
    ctl_q_t q;
    int legal;
    for (int i = 0; i <= L; i++)
      q.push_back(c(S_FETCH, 1, 0, int'(i == L), 0, int'(i == L), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    legal = int'(o inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI,
                           OP_LW, OP_SW} || (o == OP_JAL && jal != 0));
    q.push_back(c(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, int'(legal == 0)));
    if (legal == 0) return q;
    case (o)
      OP_LW, OP_SW: begin
        q.push_back(c(S_MEM_ADDR, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0));
        for (int i = 0; i <= L; i++)
          if (o == OP_LW) q.push_back(c(S_MEM_READ, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
          else            q.push_back(c(S_MEM_WRITE, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        if (o == OP_LW) q.push_back(c(S_MEM_WB, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
      OP_RTYPE: begin
        q.push_back(c(S_R_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0));
        q.push_back(c(S_ALU_WB, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        if (o == OP_ADDI) q.push_back(c(S_I_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0));
        else              q.push_back(c(S_I_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 4, 0));
        q.push_back(c(S_I_WB, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      OP_BEQ, OP_BNE:
        q.push_back(c(S_BRANCH, 0, 0, 0, 0, 0, 1, int'(o == OP_BNE), 1, 0, 0, 0, 1, 1, 0, 0));
      OP_J:
        q.push_back(c(S_JUMP, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
      default:
        q.push_back(c(S_JAL_LINK, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 2, 0, 2, 0, 0));
    endcase
    return q;
  endfunction

  task automatic cmp(string nm, int k, int cyc, ctl_t exp);
    checks++;
    if (act[k] !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc%0d: got %h expected %h", nm, k, cyc, act[k], exp);
    end
  endtask

  // Reset sampled on one edge, released just after it: next cycle is cycle 1.
  task automatic reset_all();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [5:0] pick();
    case ($urandom_range(0, 11))
      0: return OP_RTYPE;  1: return OP_J;    2: return OP_JAL;  3: return OP_BEQ;
      4: return OP_BNE;    5: return OP_ADDI; 6: return OP_ANDI; 7: return OP_ORI;
      8: return OP_LW;     9: return OP_SW;   10: return 6'b111111;
      default: return 6'($urandom);
    endcase
  endfunction

  // Random instruction stream on one instance; the opcode is held only in
  // the cycles where it may be sampled and scrambled everywhere else.
  task automatic run_rand(int k, int n);
    ctl_q_t q;
    logic [5:0] o;
    int L;
    L = lat_of(k);
    for (int t = 0; t < n; t++) begin
      o = pick();
      q = model(o, L, jal_of(k));
      for (int i = 0; i < q.size(); i++) begin
        op[k] = (i == L + 1 || i == L + 2) ? o : 6'($urandom);
        @(negedge clk);
        cmp("rand", k, i + 1, q[i]);
        @(posedge clk); #1;
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    for (int k = 0; k < ND; k++) op[k] = 6'b0;

    tbl.push_back('{0, OP_RTYPE, 3, c(S_R_EXEC, 0,0,0,0,0,0,0,1,0, 0,0,2,0,0,0), "rtype_exec"});
    tbl.push_back('{0, OP_RTYPE, 4, c(S_ALU_WB, 0,0,0,1,0,0,0,0,0, 1,0,0,0,0,0), "rtype_wb"});
    tbl.push_back('{0, OP_RTYPE, 5, c(S_FETCH, 1,0,1,0,1,0,0,0,0, 0,0,0,0,1,0), "rtype_refetch"});
    tbl.push_back('{1, OP_LW, 2, c(S_FETCH, 1,0,0,0,0,0,0,0,0, 0,0,0,0,1,0), "lw_fetch_wait"});
    tbl.push_back('{1, OP_LW, 3, c(S_FETCH, 1,0,1,0,1,0,0,0,0, 0,0,0,0,1,0), "lw_fetch_last"});
    tbl.push_back('{1, OP_LW, 5, c(S_MEM_ADDR, 0,0,0,0,0,0,0,1,0, 0,0,0,0,2,0), "lw_addr"});
    tbl.push_back('{1, OP_LW, 6, c(S_MEM_READ, 1,0,0,0,0,0,0,0,1, 0,0,0,0,0,0), "lw_read_first"});
    tbl.push_back('{1, OP_LW, 8, c(S_MEM_READ, 1,0,0,0,0,0,0,0,1, 0,0,0,0,0,0), "lw_read_last"});
    tbl.push_back('{1, OP_LW, 9, c(S_MEM_WB, 0,0,0,1,0,0,0,0,0, 0,1,0,0,0,0), "lw_wb"});
    tbl.push_back('{0, OP_BNE, 3, c(S_BRANCH, 0,0,0,0,0,1,1,1,0, 0,0,1,1,0,0), "bne"});
    tbl.push_back('{0, OP_BEQ, 3, c(S_BRANCH, 0,0,0,0,0,1,0,1,0, 0,0,1,1,0,0), "beq"});
    tbl.push_back('{0, OP_JAL, 3, c(S_JAL_LINK, 0,0,0,1,1,0,0,0,0, 2,2,0,2,0,0), "jal_link"});
    tbl.push_back('{3, OP_JAL, 2, c(S_DECODE, 0,0,0,0,0,0,0,0,0, 0,0,0,0,3,1), "jal_off_illegal"});
    tbl.push_back('{3, OP_JAL, 3, c(S_FETCH, 1,0,1,0,1,0,0,0,0, 0,0,0,0,1,0), "jal_off_refetch"});
    tbl.push_back('{0, 6'b111111, 2, c(S_DECODE, 0,0,0,0,0,0,0,0,0, 0,0,0,0,3,1), "illegal_pulse"});
    tbl.push_back('{0, 6'b111111, 3, c(S_FETCH, 1,0,1,0,1,0,0,0,0, 0,0,0,0,1,0), "illegal_after"});
    tbl.push_back('{0, OP_ANDI, 3, c(S_I_EXEC, 0,0,0,0,0,0,0,1,0, 0,0,3,0,4,0), "andi_exec"});
    tbl.push_back('{0, OP_ADDI, 3, c(S_I_EXEC, 0,0,0,0,0,0,0,1,0, 0,0,0,0,2,0), "addi_exec"});
    tbl.push_back('{0, OP_ORI, 4, c(S_I_WB, 0,0,0,1,0,0,0,0,0, 0,0,0,0,0,0), "ori_wb"});
    tbl.push_back('{0, OP_J, 3, c(S_JUMP, 0,0,0,0,1,0,0,0,0, 0,0,0,2,0,0), "jump"});
    tbl.push_back('{0, OP_SW, 4, c(S_MEM_WRITE, 0,1,0,0,0,0,0,0,1, 0,0,0,0,0,0), "sw_write"});

    // Outputs while held in reset: FETCH values, IRWrite/PCWrite only at L=0.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < ND; k++)
      cmp("in_reset", k, 0, c(S_FETCH, 1, 0, int'(lat_of(k) == 0), 0, int'(lat_of(k) == 0),
                             0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Directed vectors: opcode held constant, check one cycle of one instance.
    foreach (tbl[n]) begin
      reset_all();
      for (int i = 1; i <= tbl[n].cyc; i++) begin
        for (int k = 0; k < ND; k++) op[k] = tbl[n].o;
        @(negedge clk);
        if (i == tbl[n].cyc) cmp(tbl[n].nm, tbl[n].k, i, tbl[n].exp);
        @(posedge clk); #1;
      end
    end

    // L=3 SW with reset in the second MEM_WRITE cycle, then a full refetch.
    reset_all();
    for (int k = 0; k < ND; k++) op[k] = OP_SW;
    repeat (7) begin @(negedge clk); @(posedge clk); #1; end
    @(negedge clk);
    cmp("sw_mid_write", 2, 8, c(S_MEM_WRITE, 0,1,0,0,0,0,0,0,1, 0,0,0,0,0,0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    cmp("sw_rst_fetch", 2, 9, c(S_FETCH, 1,0,0,0,0,0,0,0,0, 0,0,0,0,1,0));
    repeat (3) @(negedge clk);
    cmp("sw_rst_refetch_last", 2, 12, c(S_FETCH, 1,0,1,0,1,0,0,0,0, 0,0,0,0,1,0));
    @(posedge clk); #1;

    // Randomized instruction streams on all instances in parallel.
    reset_all();
    fork
      run_rand(0, 40);
      run_rand(1, 40);
      run_rand(2, 40);
      run_rand(3, 40);
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
